// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, functs, ALU/mux codes, sequencer states and the control word.
package mcpu_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned SRCB_W = 2;
    localparam int unsigned PCS_W  = 2;
    localparam int unsigned CNT_W  = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SRCB_W-1:0] SRCB_RT     = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [PCS_W-1:0] PCS_ALU    = 2'b00;
    localparam logic [PCS_W-1:0] PCS_ALUOUT = 2'b01;
    localparam logic [PCS_W-1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_e;

    typedef struct packed {
        logic              mem_req;
        logic              mem_write;
        logic              i_or_d;
        logic              ir_write;
        logic              pc_en;
        logic [PCS_W-1:0]  pc_src;
        logic              alu_src_a;
        logic [SRCB_W-1:0] alu_src_b;
        logic              ext_op;
        logic [ALU_W-1:0]  alu_ctr;
        logic              reg_dst;
        logic              mem_to_reg;
        logic              reg_write;
        logic              illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;
    import mcpu_pkg::*;

    logic [OP_W-1:0]   op;
    logic [FN_W-1:0]   funct;
    logic              zero;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_write;
    logic              i_or_d;
    logic              ir_write;
    logic              pc_en;
    logic [PCS_W-1:0]  pc_src;
    logic              alu_src_a;
    logic [SRCB_W-1:0] alu_src_b;
    logic              ext_op;
    logic [ALU_W-1:0]  alu_ctr;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              reg_write;
    logic              illegal;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, ext_op, alu_ctr, reg_dst,
               mem_to_reg, reg_write, illegal, retire_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, ext_op, alu_ctr, reg_dst,
               mem_to_reg, reg_write, illegal, retire_cnt
    );

endinterface

// File: rtl/alu_decode.sv
// R-type funct to ALU control; flags functs outside the supported set.
module alu_decode
    import mcpu_pkg::*;
(
    input  logic [FN_W-1:0]  funct,
    output logic [ALU_W-1:0] alu_ctr,
    output logic             funct_illegal
);

    always_comb begin
        alu_ctr       = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctr = ALU_ADD;
            FN_SUB:  alu_ctr = ALU_SUB;
            FN_AND:  alu_ctr = ALU_AND;
            FN_OR:   alu_ctr = ALU_OR;
            FN_SLT:  alu_ctr = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer driving a shared ALU and memory,
// with ready-based memory wait states and a retired-instruction counter.
module multicycle_control_fsm
    import mcpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    multicycle_control_fsm_if.master bus
);

    state_e           state;
    state_e           state_nxt;
    ctrl_t            ctrl;
    ctrl_t            ctrl_gated;
    logic [ALU_W-1:0] funct_alu_ctr;
    logic             funct_illegal;
    logic [CNT_W-1:0] retire_cnt;

    alu_decode u_alu_decode (
        .funct         (bus.funct),
        .alu_ctr       (funct_alu_ctr),
        .funct_illegal (funct_illegal)
    );

    // Every re-entry into FETCH marks the previous instruction as retired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_FETCH && state != S_FETCH) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctr   = ALU_ADD;
                ctrl.pc_src    = PCS_ALU;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.ext_op    = 1'b1;
                ctrl.alu_ctr   = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = funct_illegal ? S_ILLEGAL : S_EXEC_R;
                    OP_ORI:       state_nxt = S_EXEC_I;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
                ctrl.alu_ctr   = ALU_ADD;
                state_nxt      = (bus.op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
                if (bus.mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_ctr   = funct_alu_ctr;
                state_nxt      = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_ctr   = funct_alu_ctr;
                state_nxt      = S_FETCH;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctr   = ALU_OR;
                state_nxt      = S_I_WB;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_ctr   = ALU_SUB;
                ctrl.pc_src    = PCS_ALUOUT;
                ctrl.pc_en     = bus.zero;
                state_nxt      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src = PCS_JUMP;
                ctrl.pc_en  = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                state_nxt = S_ILLEGAL;
            end
        endcase
    end

    // Reset squashes every strobe combinationally, including mid-access.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign bus.mem_req    = ctrl_gated.mem_req;
    assign bus.mem_write  = ctrl_gated.mem_write;
    assign bus.i_or_d     = ctrl_gated.i_or_d;
    assign bus.ir_write   = ctrl_gated.ir_write;
    assign bus.pc_en      = ctrl_gated.pc_en;
    assign bus.pc_src     = ctrl_gated.pc_src;
    assign bus.alu_src_a  = ctrl_gated.alu_src_a;
    assign bus.alu_src_b  = ctrl_gated.alu_src_b;
    assign bus.ext_op     = ctrl_gated.ext_op;
    assign bus.alu_ctr    = ctrl_gated.alu_ctr;
    assign bus.reg_dst    = ctrl_gated.reg_dst;
    assign bus.mem_to_reg = ctrl_gated.mem_to_reg;
    assign bus.reg_write  = ctrl_gated.reg_write;
    assign bus.illegal    = ctrl_gated.illegal;
    assign bus.retire_cnt = rst_n ? retire_cnt : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against a per-instruction
// step-list reference model with random memory wait states.
module tb_multicycle_control_fsm;

    localparam logic [5:0] T_R   = 6'b000000;
    localparam logic [5:0] T_ORI = 6'b001101;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100;
    localparam logic [5:0] T_J   = 6'b000010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus_if ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_retire;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // {illegal_funct, alu_ctr}
    function automatic logic [3:0] ref_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0_010;
            6'b100010: return 4'b0_110;
            6'b100100: return 4'b0_000;
            6'b100101: return 4'b0_001;
            6'b101010: return 4'b0_111;
            default:   return 4'b1_000;
        endcase
    endfunction

    // Control vector order: mem_req mem_write i_or_d ir_write pc_en pc_src[2]
    // alu_src_a alu_src_b[2] ext_op alu_ctr[3] reg_dst mem_to_reg reg_write illegal
    function automatic logic [18:0] exp_vec(input string ph, input logic mr, input logic z,
                                            input logic [5:0] f);
        logic mreq, mwr, iod, irw, pce, srca, ext, rdst, m2r, rw, ill;
        logic [1:0] pcs, srcb;
        logic [2:0] alu;
        logic [3:0] fd;
        {mreq, mwr, iod, irw, pce, srca, ext, rdst, m2r, rw, ill} = '0;
        pcs  = 2'b00;
        srcb = 2'b00;
        alu  = 3'b000;
        fd   = ref_funct(f);
        case (ph)
            "fetch":     begin mreq = 1; srcb = 2'b01; alu = 3'b010; irw = mr; pce = mr; end
            "decode":    begin srcb = 2'b11; ext = 1; alu = 3'b010; end
            "mem_addr":  begin srca = 1; srcb = 2'b10; ext = 1; alu = 3'b010; end
            "mem_read":  begin mreq = 1; iod = 1; end
            "mem_wb":    begin rw = 1; m2r = 1; end
            "mem_write": begin mreq = 1; mwr = 1; iod = 1; end
            "exec_r":    begin srca = 1; alu = fd[2:0]; end
            "r_wb":      begin rw = 1; rdst = 1; alu = fd[2:0]; end
            "exec_i":    begin srca = 1; srcb = 2'b10; alu = 3'b001; end
            "i_wb":      begin rw = 1; end
            "branch":    begin srca = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
            "jump":      begin pcs = 2'b10; pce = 1; end
            "illegal":   begin ill = 1; end
            default:     ;
        endcase
        return {mreq, mwr, iod, irw, pce, pcs, srca, srcb, ext, alu, rdst, m2r, rw, ill};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus_if.mem_req, bus_if.mem_write, bus_if.i_or_d, bus_if.ir_write,
                bus_if.pc_en, bus_if.pc_src, bus_if.alu_src_a, bus_if.alu_src_b,
                bus_if.ext_op, bus_if.alu_ctr, bus_if.reg_dst, bus_if.mem_to_reg,
                bus_if.reg_write, bus_if.illegal};
    endfunction

    // One clock: drive inputs just after the edge, check outputs 1ns later.
    task automatic step(input string ph, input logic rn, input logic mr, input logic z,
                        input logic [5:0] o, input logic [5:0] f);
        @(posedge clk);
        #1;
        rst_n            = rn;
        bus_if.mem_ready = mr;
        bus_if.zero      = z;
        bus_if.op        = o;
        bus_if.funct     = f;
        #1;
        chk(ph, 32'(dut_vec()), 32'(exp_vec(ph, mr, z, f)));
        if (!rn) chk("retire_in_reset", bus_if.retire_cnt, 32'd0);
    endtask

    // Memory-handshake phase: w wait cycles then the ready cycle.
    task automatic mem_phase(input string ph, input int w, input logic [5:0] o,
                             input logic [5:0] f, input bit rand_ir);
        logic [5:0] oo, ff;
        for (int i = 0; i <= w; i++) begin
            oo = rand_ir ? 6'($urandom) : o;
            ff = rand_ir ? 6'($urandom) : f;
            step(ph, 1'b1, (i == w), rb(), oo, ff);
            if (ph == "fetch" && i == 0) chk("retire_cnt", bus_if.retire_cnt, exp_retire);
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int dw);
        logic [3:0] fd;
        bit         bad;
        fd  = ref_funct(f);
        bad = 1'b0;
        mem_phase("fetch", fw, o, f, 1'b1);
        step("decode", 1'b1, rb(), rb(), o, f);
        case (o)
            T_LW: begin
                step("mem_addr", 1'b1, rb(), rb(), o, f);
                mem_phase("mem_read", dw, o, f, 1'b0);
                step("mem_wb", 1'b1, rb(), rb(), o, f);
            end
            T_SW: begin
                step("mem_addr", 1'b1, rb(), rb(), o, f);
                mem_phase("mem_write", dw, o, f, 1'b0);
            end
            T_R: begin
                if (fd[3]) bad = 1'b1;
                else begin
                    step("exec_r", 1'b1, rb(), rb(), o, f);
                    step("r_wb", 1'b1, rb(), rb(), o, f);
                end
            end
            T_ORI: begin
                step("exec_i", 1'b1, rb(), rb(), o, f);
                step("i_wb", 1'b1, rb(), rb(), o, f);
            end
            T_BEQ: step("branch", 1'b1, rb(), z, o, f);
            T_J:   step("jump", 1'b1, rb(), rb(), o, f);
            default: bad = 1'b1;
        endcase
        if (bad) begin
            for (int i = 0; i < 10; i++) step("illegal", 1'b1, rb(), rb(), o, f);
            step("reset", 1'b0, 1'b1, rb(), o, f);
            exp_retire = '0;
        end else begin
            exp_retire = exp_retire + 32'd1;
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        logic [5:0] o, f;
        ops = '{T_R, T_ORI, T_LW, T_SW, T_BEQ, T_J};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst_n            = 1'b0;
        bus_if.op        = '0;
        bus_if.funct     = '0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;
        exp_retire       = '0;

        step("reset", 1'b0, 1'b1, 1'b1, T_SW, 6'd0);
        step("reset", 1'b0, 1'b1, 1'b1, T_LW, 6'd0);

        run_instr(T_LW, 6'd0, 1'b0, 0, 0);
        run_instr(T_SW, 6'd0, 1'b0, 0, 3);
        run_instr(T_BEQ, 6'd0, 1'b1, 0, 0);
        run_instr(T_BEQ, 6'd0, 1'b0, 1, 0);
        run_instr(T_R, 6'b101010, 1'b0, 0, 0);
        run_instr(T_ORI, 6'd0, 1'b0, 2, 0);

        // Reset in the middle of a load's memory wait
        mem_phase("fetch", 0, T_LW, 6'd0, 1'b1);
        chk("retire_before_abort", bus_if.retire_cnt, exp_retire);
        step("decode", 1'b1, 1'b1, rb(), T_LW, 6'd0);
        step("mem_addr", 1'b1, 1'b1, rb(), T_LW, 6'd0);
        step("mem_read", 1'b1, 1'b0, rb(), T_LW, 6'd0);
        step("mem_read", 1'b1, 1'b0, rb(), T_LW, 6'd0);
        step("reset", 1'b0, 1'b1, rb(), T_LW, 6'd0);
        exp_retire = '0;

        run_instr(T_R, 6'b000111, 1'b0, 0, 0);
        run_instr(T_J, 6'd0, 1'b0, 0, 0);

        // Counter wrap: preload all-ones while a J sits in DECODE
        mem_phase("fetch", 0, T_J, 6'd0, 1'b1);
        step("decode", 1'b1, rb(), rb(), T_J, 6'd0);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        step("jump", 1'b1, rb(), rb(), T_J, 6'd0);
        chk("retire_preloaded", bus_if.retire_cnt, 32'hFFFF_FFFF);
        exp_retire = 32'hFFFF_FFFF + 32'd1;

        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 5)];
            f = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 14) == 0) begin
                if (rb()) f = 6'($urandom);
                else      o = 6'b111111;
            end
            run_instr(o, f, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mem_phase("fetch", 0, T_J, 6'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the MIPS-subset datapath (R-type add/sub/and/or/slt, ORI, LW, SW, BEQ, J). It replaces single-cycle decode with a per-instruction state machine that steps one shared ALU and one shared instruction/data memory through fetch, decode, execute, memory and writeback. It also handles a ready-based memory handshake with wait states and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- op  in  6  opcode field from the instruction register (IR)
- funct  in  6  funct field from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion for the current request
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write (valid only with mem_req)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- pc_en  out  1  PC load enable
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs register
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- alu_ctr  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data register (MDR), 0 = ALUOut
- reg_write  out  1  register file write enable
- illegal  out  1  unsupported opcode or funct trapped
- retire_cnt  out  32  retired-instruction count

## Operation
- Opcodes:
  - 000000 R-type
  - 001101 ORI
  - 100011 LW
  - 101011 SW
  - 000100 BEQ
  - 000010 J
- R-type funct[5:0]:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - any other funct → ILLEGAL
- States and actions; any output not listed is 0:
  - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=add, pc_src=00. While mem_ready=0, stay in FETCH. On the cycle mem_ready=1, assert ir_write=1 and pc_en=1, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=add (computes the branch target). Next state by opcode: LW/SW → MEM_ADDR, R → EXEC_R, ORI → EXEC_I, BEQ → BRANCH, J → JUMP, other → ILLEGAL.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctr=add. Next: LW → MEM_READ, SW → MEM_WRITE.
  - MEM_READ: mem_req=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
  - MEM_WRITE: mem_req=1, mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctr from funct. Next: R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctr held from funct. Next: FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctr=or. Next: I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctr=sub, pc_src=01, pc_en=zero. Next: FETCH.
  - JUMP: pc_src=10, pc_en=1. Next: FETCH.
  - ILLEGAL: illegal=1, all other outputs 0. Sticky until reset.
- retire_cnt increments by 1 on every transition into FETCH from a non-reset state. It wraps from 0xFFFFFFFF to 0. No saturation.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset: while rst_n=0 at a rising edge, state ← FETCH and retire_cnt ← 0. While rst_n=0, every output is forced to 0, including mem_req.
- The first fetch request appears in the first cycle with rst_n=1.
- Reset asserted mid-instruction (including during a memory wait) aborts the instruction. No write strobe may be asserted while rst_n=0.
- Outputs are combinational from state, plus mem_ready (ir_write, pc_en in FETCH) and zero (pc_en in BRANCH). There are no output registers.
- Minimum cycles per instruction with mem_ready=1 on first request:
  - J, BEQ: 3
  - R, ORI, SW: 4
  - LW: 5
- Each wait cycle with mem_ready=0 adds exactly one cycle.
- mem_req stays high continuously from the first request cycle through the mem_ready cycle. mem_write, i_or_d and the address source are stable for that whole span.

## Structure
- Shared package `mcpu_pkg`:
  - opcode and funct constants
  - alu_ctr codes
  - alu_src_b and pc_src encodings
  - state enum
- Sub-module `alu_decode`: combinational mapping funct → {alu_ctr, funct_illegal}. It is used in EXEC_R and R_WB; DECODE uses funct_illegal to route to ILLEGAL.

## Test plan
- Reset then LW, mem_ready=1 always → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_write=1 in cycle 5 only; retire_cnt=1 after cycle 5.
- SW with mem_ready low for 3 cycles in MEM_WRITE → mem_req=mem_write=1 for 4 consecutive cycles; 7 cycles total.
- BEQ with zero=1, then zero=0 → pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 in BRANCH for the second.
- R-type funct 101010 → alu_ctr=111 in EXEC_R; funct 000111 → ILLEGAL with illegal=1 held across 10 cycles.
- rst_n low during a MEM_READ wait → all outputs 0 that cycle; mem_req=1 in FETCH on the next cycle with rst_n=1; retire_cnt=0.
- Force retire_cnt to 0xFFFFFFFF, then complete a J → retire_cnt=0.
